// File: rtl/dtw_core_feeder.sv
// dtw_core_feeder: loads one query squiggle, then resets, streams, drains and
// reads back a DTW systolic datapath; the reference comes from an external RAM.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : job control pulses; ref_len latched on start
//   q_valid/q_ready/q_data      : query sample stream (ready only while loading)
//   ref_addr/ref_rdata          : reference RAM port, one-cycle read latency
//   dp_rst/dp_running/dp_squiggle/dp_rword/dp_ref_len : datapath drive
//   dp_done/dp_minval/dp_position                     : datapath status
//   res_valid/res_ready/res_minval/res_position       : result handshake
//   busy              : high whenever a job is in flight
module dtw_core_feeder #(
  parameter int width    = 16,
  parameter int SQG_SIZE = 256,
  parameter int REF_AW   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       ref_len,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [width-1:0]  q_data,
  output logic [REF_AW-1:0] ref_addr,
  input  logic [width-1:0]  ref_rdata,
  output logic              dp_rst,
  output logic              dp_running,
  output logic [width-1:0]  dp_squiggle,
  output logic [width-1:0]  dp_rword,
  output logic [31:0]       dp_ref_len,
  input  logic              dp_done,
  input  logic [width-1:0]  dp_minval,
  input  logic [31:0]       dp_position,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [width-1:0]  res_minval,
  output logic [31:0]       res_position,
  output logic              busy
);

  localparam int QW = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t            r_state;
  logic [QW-1:0]     r_qidx;
  logic [31:0]       r_c;
  logic [REF_AW-1:0] r_aidx;
  logic [31:0]       r_len;
  logic              r_drain;
  logic              r_q_ready;
  logic              r_dp_rst;
  logic              r_dp_run;
  logic [width-1:0]  r_sq;
  logic [width-1:0]  r_rw;
  logic              r_res_valid;
  logic [width-1:0]  r_res_min;
  logic [31:0]       r_res_pos;
  logic [width-1:0]  r_buf [SQG_SIZE];

  logic              w_q_acc;
  logic              w_last_q;
  logic [31:0]       w_len_m1;
  logic [31:0]       w_aidx32;
  logic              w_c_sq;
  logic              w_c_rf;
  logic              w_abort;
  logic [REF_AW-1:0] w_aidx_nxt;

  assign w_q_acc  = q_valid & r_q_ready;
  assign w_last_q = (r_qidx == QW'(SQG_SIZE - 1));
  assign w_len_m1 = r_len - 32'd1;
  assign w_aidx32 = {{(32-REF_AW){1'b0}}, r_aidx};
  // r_c is the index of the sample to present next cycle
  assign w_c_sq   = (r_c < 32'(SQG_SIZE));
  assign w_c_rf   = (r_c < r_len);
  // address runs one ahead and parks on the last reference sample
  assign w_aidx_nxt = (w_aidx32 < w_len_m1) ? r_aidx + 1'b1 : r_aidx;
  assign w_abort  = abort & (r_state != S_IDLE) & (r_state != S_RESULT);

  always_ff @(posedge clk) begin
    if (w_q_acc) r_buf[r_qidx] <= q_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_qidx      <= '0;
      r_c         <= '0;
      r_aidx      <= '0;
      r_len       <= '0;
      r_drain     <= 1'b0;
      r_q_ready   <= 1'b0;
      r_dp_rst    <= 1'b1;
      r_dp_run    <= 1'b0;
      r_sq        <= '0;
      r_rw        <= '0;
      r_res_valid <= 1'b0;
      r_res_min   <= '1;
      r_res_pos   <= '0;
    end else if (w_abort) begin
      r_state   <= S_IDLE;
      r_q_ready <= 1'b0;
      r_dp_rst  <= 1'b1;
      r_dp_run  <= 1'b0;
      r_sq      <= '0;
      r_rw      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len <= ref_len;
            if (ref_len == 32'd0) begin
              r_state     <= S_RESULT;
              r_res_valid <= 1'b1;
              r_res_min   <= '1;
              r_res_pos   <= '0;
            end else begin
              r_state   <= S_LOAD;
              r_q_ready <= 1'b1;
              r_qidx    <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_q_acc) begin
            r_qidx <= r_qidx + 1'b1;
            if (w_last_q) begin
              r_state   <= S_CLEAR;
              r_q_ready <= 1'b0;
              r_c       <= '0;
              r_aidx    <= '0;
            end
          end
        end
        S_CLEAR: begin
          r_state  <= S_STREAM;
          r_dp_rst <= 1'b0;
          r_dp_run <= 1'b1;
          r_sq     <= '0;
          r_rw     <= '0;
          r_c      <= '0;
          r_aidx   <= (r_len > 32'd1) ? REF_AW'(1) : '0;
        end
        S_STREAM: begin
          if (dp_done) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
            r_sq    <= '0;
            r_rw    <= '0;
          end else begin
            r_c    <= r_c + 32'd1;
            r_sq   <= w_c_sq ? r_buf[r_c[QW-1:0]] : '0;
            r_rw   <= w_c_rf ? ref_rdata : '0;
            r_aidx <= w_aidx_nxt;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state     <= S_RESULT;
            r_dp_run    <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_min   <= dp_minval;
            r_res_pos   <= dp_position;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_dp_rst    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign q_ready      = r_q_ready;
  assign ref_addr     = r_aidx;
  assign dp_rst       = r_dp_rst;
  assign dp_running   = r_dp_run;
  assign dp_squiggle  = r_sq;
  assign dp_rword     = r_rw;
  assign dp_ref_len   = r_len;
  assign res_valid    = r_res_valid;
  assign res_minval   = r_res_min;
  assign res_position = r_res_pos;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_dtw_core_feeder.sv
// Bench for dtw_core_feeder: SQG_SIZE=4, reference RAM holds 100+i,
// behavioural datapath stub raises done at stream cycle 9.
module tb_dtw_core_feeder;

  localparam int W  = 16;
  localparam int SQ = 4;
  localparam int AW = 20;
  localparam int DONE_C = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   ref_len = '0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [W-1:0]  q_data = '0;
  logic [AW-1:0] ref_addr;
  logic [W-1:0]  ref_rdata = '0;
  logic          dp_rst;
  logic          dp_running;
  logic [W-1:0]  dp_squiggle;
  logic [W-1:0]  dp_rword;
  logic [31:0]   dp_ref_len;
  logic          dp_done = 1'b0;
  logic [W-1:0]  dp_minval;
  logic [31:0]   dp_position;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_minval;
  logic [31:0]   res_position;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] qm [SQ];
  logic [31:0]  cur_len = '0;
  logic [W-1:0] stub_min = 16'h0123;
  logic [31:0]  stub_pos = 32'd7;
  int rc = 0;
  int last_run = 0;
  bit was_run = 0;
  bit ran_any = 0;
  logic [W-1:0] logw [16];
  logic [W-1:0] logs [16];

  assign dp_minval   = stub_min;
  assign dp_position = stub_pos;

  dtw_core_feeder #(.width(W), .SQG_SIZE(SQ), .REF_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ref_len(ref_len), .q_valid(q_valid), .q_ready(q_ready),
    .q_data(q_data), .ref_addr(ref_addr), .ref_rdata(ref_rdata),
    .dp_rst(dp_rst), .dp_running(dp_running),
    .dp_squiggle(dp_squiggle), .dp_rword(dp_rword),
    .dp_ref_len(dp_ref_len), .dp_done(dp_done),
    .dp_minval(dp_minval), .dp_position(dp_position),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_minval(res_minval), .res_position(res_position),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous-read reference RAM: RAM[i] = 100 + i
  always @(posedge clk) ref_rdata <= W'(32'd100 + 32'(ref_addr));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: stream cycle k shows query[k-1] and reference[k-1] when in range
  always @(negedge clk) begin
    if (dp_running) begin
      logic [W-1:0] e_sq;
      logic [W-1:0] e_rw;
      e_sq = '0;
      e_rw = '0;
      if (rc >= 1 && rc <= SQ) e_sq = qm[rc-1];
      if (rc >= 1 && 32'(rc) <= cur_len) e_rw = W'(100 + rc - 1);
      if (rc < 16) begin
        logw[rc] = dp_rword;
        logs[rc] = dp_squiggle;
      end
      chk("run_dp_rst", 32'(dp_rst), 32'd0);
      chk("run_ref_len", dp_ref_len, cur_len);
      if (rc <= DONE_C) begin
        chk("stream_rword", 32'(dp_rword), 32'(e_rw));
        chk("stream_squig", 32'(dp_squiggle), 32'(e_sq));
        chk("addr_sat", 32'(32'(ref_addr) <= cur_len - 1), 32'd1);
      end else begin
        chk("drain_rword", 32'(dp_rword), 32'd0);
      end
      dp_done = (rc == DONE_C);
      rc++;
      was_run = 1;
      ran_any = 1;
    end else begin
      dp_done = 1'b0;
      if (was_run) last_run = rc;
      rc = 0;
      was_run = 0;
    end
  end

  task automatic start_job(input logic [31:0] len);
    ref_len = len;
    cur_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ends at the negedge of stream cycle 0
  task automatic load_run(input logic [31:0] len);
    int n;
    int hi;
    n = 0;
    hi = 0;
    q_valid = 1'b1;
    start_job(len);
    for (int i = 0; i < 20 && n < SQ; i++) begin
      if (q_ready) begin
        q_data = qm[n];
        n++;
        hi++;
      end
      @(negedge clk);
    end
    if (q_ready) hi++;
    chk("clear_rst", 32'(dp_rst), 32'd1);
    chk("clear_run", 32'(dp_running), 32'd0);
    @(negedge clk);
    if (q_ready) hi++;
    q_valid = 1'b0;
    chk("q_beats", 32'(hi), 32'(SQ));
    chk("c0_run", 32'(dp_running), 32'd1);
    chk("c0_rword", 32'(dp_rword), 32'd0);
  endtask

  task automatic wait_res();
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    chk("res_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dp_rst"}, 32'(dp_rst), 32'd1);
    chk({tag, "_run"}, 32'(dp_running), 32'd0);
    chk({tag, "_q_ready"}, 32'(q_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_minval"}, 32'(res_minval), 32'h0000FFFF);
    chk({tag, "_pos"}, res_position, 32'd0);
    chk({tag, "_addr"}, 32'(ref_addr), 32'd0);
    chk({tag, "_sq_rw"}, 32'({dp_squiggle, dp_rword}), 32'd0);
    chk({tag, "_ref_len"}, dp_ref_len, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // job 1: query 10..40, ref_len 6, result 0x0123 @ 7
    qm[0] = 16'd10; qm[1] = 16'd20; qm[2] = 16'd30; qm[3] = 16'd40;
    load_run(32'd6);
    wait_res();
    chk("j1_run_low", 32'(dp_running), 32'd0);
    chk("j1_minval", 32'(res_minval), 32'h0123);
    chk("j1_pos", res_position, 32'd7);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      abort = (i == 2);
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_min", 32'(res_minval), 32'h0123);
      chk("hold_pos", res_position, 32'd7);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_noload", 32'(q_ready), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    chk("j1_run_len", 32'(last_run), 32'(DONE_C + 3));
    chk("lit_rw1", 32'(logw[1]), 32'd100);
    chk("lit_rw6", 32'(logw[6]), 32'd105);
    chk("lit_rw7", 32'(logw[7]), 32'd0);
    chk("lit_sq4", 32'(logs[4]), 32'd40);
    chk("lit_sq5", 32'(logs[5]), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("j1_ack_valid", 32'(res_valid), 32'd0);
    chk("j1_ack_busy", 32'(busy), 32'd0);
    chk("j1_ack_rst", 32'(dp_rst), 32'd1);

    // zero-length reference
    ran_any = 0;
    start_job(32'd0);
    chk("z_valid", 32'(res_valid), 32'd1);
    chk("z_min", 32'(res_minval), 32'h0000FFFF);
    chk("z_pos", res_position, 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("z_ack", 32'(res_valid), 32'd0);
    chk("z_never_ran", 32'(ran_any), 32'd0);

    // abort at stream cycle 3
    load_run(32'd6);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_rst", 32'(dp_rst), 32'd1);
    chk("ab_run", 32'(dp_running), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("ab_no_res", 32'(res_valid), 32'd0);
    end

    // fresh job after abort: short reference, new query and stub result
    qm[0] = 16'd5; qm[1] = 16'd6; qm[2] = 16'd7; qm[3] = 16'd8;
    stub_min = 16'h0042;
    stub_pos = 32'd2;
    load_run(32'd3);
    wait_res();
    chk("j3_minval", 32'(res_minval), 32'h0042);
    chk("j3_pos", res_position, 32'd2);
    chk("j3_lit_rw3", 32'(logw[3]), 32'd102);
    chk("j3_lit_rw4", 32'(logw[4]), 32'd0);
    chk("j3_lit_sq4", 32'(logs[4]), 32'd8);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("j3_ack", 32'(res_valid), 32'd0);

    // asynchronous reset during streaming
    load_run(32'd6);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    cur_len = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("mid_no_res", 32'(res_valid | busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
